// File: rtl/clock_step_controller_pkg.sv
// Shared definitions for the clock step controller.
// Contents: FSM state encoding, divider counter width, key index constants,
// and a small helper that says whether a state issues rate-driven enables.
package clock_step_controller_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_MANUAL = 2'd0;
  localparam state_t ST_RUN    = 2'd1;
  localparam state_t ST_BURST  = 2'd2;
  localparam state_t ST_HALT   = 2'd3;

  localparam int unsigned DIV_W = 26;

  localparam int unsigned KEY_STEP = 2;
  localparam int unsigned KEY_AUTO = 1;
  localparam int unsigned KEY_FAST = 0;

  // RUN and BURST are the only states in which the rate divider counts.
  function automatic logic is_running(input state_t st);
    return (st == ST_RUN) || (st == ST_BURST);
  endfunction

endpackage

// File: rtl/clock_step_controller_if.sv
// Control/status bundle of the clock step controller.
// Inputs : iKEY[2:0] (active-low keys: step, auto, fast), iFDiv[7:0], iBreak,
//          iBurstStart, iBurstLen[BURST_W-1:0]
// Outputs: oCLKEn, oSelectAuto, oSelectFast, oRunning, oHalted, oCycleCount[31:0]
// Modports: master (board/testbench side), slave (controller side).
interface clock_step_controller_if #(
  parameter int unsigned BURST_W = 16
);
  logic [2:0]         iKEY;
  logic [7:0]         iFDiv;
  logic               iBreak;
  logic               iBurstStart;
  logic [BURST_W-1:0] iBurstLen;
  logic               oCLKEn;
  logic               oSelectAuto;
  logic               oSelectFast;
  logic               oRunning;
  logic               oHalted;
  logic [31:0]        oCycleCount;

  modport master (
    output iKEY, iFDiv, iBreak, iBurstStart, iBurstLen,
    input  oCLKEn, oSelectAuto, oSelectFast, oRunning, oHalted, oCycleCount
  );

  modport slave (
    input  iKEY, iFDiv, iBreak, iBurstStart, iBurstLen,
    output oCLKEn, oSelectAuto, oSelectFast, oRunning, oHalted, oCycleCount
  );
endinterface

// File: rtl/clock_step_controller_key_debounce.sv
// key_debounce: one push-button input path.
// Ports: CLK, Reset (async, active-high), i_key (raw, active-low),
//        o_press (one-cycle pulse on an accepted 1->0 transition).
// A new level is accepted after DEBOUNCE_CYCLES consecutive synchronized
// samples that differ from the currently accepted level. Releases give no pulse.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic CLK,
  input  logic Reset,
  input  logic i_key,
  output logic o_press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press;

  // Synchronizer and accepted level idle high (key released) so that leaving
  // reset never looks like a press.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 != r_level) begin
        if (r_cnt == CNT_LAST) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
          r_press <= ~r_sync2;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/clock_step_controller.sv
// clock_step_controller: sequences the core clock-enable for bring-up/debug.
// Ports: CLK, Reset (async, active-high), bus (clock_step_controller_if.slave).
// Modes: MANUAL (single-step key), RUN (free-run at divided rate), BURST
// (fixed number of enables), HALT (entered on breakpoint, left by step key).
// Optional macro CLOCK_STEP_CYCLE_COUNTER_EN: when defined oCycleCount counts
// issued enables; otherwise it is tied to zero.
module clock_step_controller
  import clock_step_controller_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned SLOW_SHIFT      = 18,
  parameter int unsigned BURST_W         = 16
) (
  input logic                   CLK,
  input logic                   Reset,
  clock_step_controller_if.slave bus
);

  logic [2:0]         w_press;
  state_t             r_state;
  state_t             w_state_d;
  logic [DIV_W-1:0]   r_div;
  logic [DIV_W-1:0]   w_div_d;
  logic [BURST_W-1:0] r_remain;
  logic [BURST_W-1:0] w_remain_d;
  logic               r_clken;
  logic               w_clken_d;
  logic               r_fast;
  logic [31:0]        w_fdiv_eff;
  logic [31:0]        w_period;
  logic               w_tick;

  for (genvar k = 0; k < 3; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
      .CLK    (CLK),
      .Reset  (Reset),
      .i_key  (bus.iKEY[k]),
      .o_press(w_press[k])
    );
  end

  // Period in CLK cycles; iFDiv = 0 behaves as 1.
  assign w_fdiv_eff = (bus.iFDiv == 8'd0) ? 32'd1 : {24'd0, bus.iFDiv};
  assign w_period   = r_fast ? w_fdiv_eff : (w_fdiv_eff << SLOW_SHIFT);
  // '>=' rather than '==' so a period shortened mid-count wraps at once.
  assign w_tick     = is_running(r_state) && (32'(r_div) >= (w_period - 32'd1));

  always_comb begin
    w_state_d  = r_state;
    w_remain_d = r_remain;
    w_clken_d  = 1'b0;
    unique case (r_state)
      ST_MANUAL: begin
        w_clken_d = w_press[KEY_STEP];
        if (bus.iBurstStart && (bus.iBurstLen != '0)) begin
          w_state_d  = ST_BURST;
          w_remain_d = bus.iBurstLen;
        end else if (w_press[KEY_AUTO]) begin
          w_state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.iBreak) begin
          w_state_d = ST_HALT;
        end else if (w_press[KEY_AUTO]) begin
          w_state_d = ST_MANUAL;
        end else begin
          w_clken_d = w_tick;
        end
      end
      ST_BURST: begin
        if (bus.iBreak) begin
          w_state_d  = ST_HALT;
          w_remain_d = '0;
        end else if (w_tick) begin
          w_clken_d  = 1'b1;
          w_remain_d = r_remain - 1'b1;
          if (r_remain == BURST_W'(1)) begin
            w_state_d = ST_MANUAL;
          end
        end
      end
      ST_HALT: begin
        if (w_press[KEY_STEP] && !bus.iBreak) begin
          w_state_d = ST_MANUAL;
        end
      end
      default: w_state_d = ST_MANUAL;
    endcase
    // Counter is held at zero outside RUN/BURST, so every entry starts fresh.
    if (is_running(r_state) && is_running(w_state_d)) begin
      w_div_d = w_tick ? '0 : r_div + 1'b1;
    end else begin
      w_div_d = '0;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state  <= ST_MANUAL;
      r_div    <= '0;
      r_remain <= '0;
      r_clken  <= 1'b0;
      r_fast   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_div    <= w_div_d;
      r_remain <= w_remain_d;
      r_clken  <= w_clken_d;
      r_fast   <= r_fast ^ w_press[KEY_FAST];
    end
  end

  assign bus.oCLKEn      = r_clken;
  assign bus.oSelectAuto = (r_state == ST_RUN);
  assign bus.oSelectFast = r_fast;
  assign bus.oRunning    = is_running(r_state);
  assign bus.oHalted     = (r_state == ST_HALT);

`ifdef CLOCK_STEP_CYCLE_COUNTER_EN
  logic [31:0] r_cycle_count;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_cycle_count <= '0;
    end else if (r_clken) begin
      r_cycle_count <= r_cycle_count + 32'd1;
    end
  end

  assign bus.oCycleCount = r_cycle_count;
`else
  assign bus.oCycleCount = '0;
`endif

endmodule

// File: tb/tb_clock_step_controller.sv
// Self-checking bench for clock_step_controller (DEBOUNCE_CYCLES=4, SLOW_SHIFT=2).
// Directed bring-up scenarios followed by randomized key/rate/break/burst
// traffic, all compared every cycle against a behavioural model.
module tb_clock_step_controller;

  localparam int unsigned DEB = 4;
  localparam int unsigned SS  = 2;
  localparam int unsigned BW  = 16;
  localparam int STEP = 2;
  localparam int AUTO = 1;
  localparam int FAST = 0;

  logic CLK = 1'b0;
  logic Reset;

  always #5 CLK = ~CLK;

  clock_step_controller_if #(.BURST_W(BW)) bus ();

  clock_step_controller #(
    .DEBOUNCE_CYCLES(DEB),
    .SLOW_SHIFT     (SS),
    .BURST_W        (BW)
  ) dut (
    .CLK  (CLK),
    .Reset(Reset),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int en_seen = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {MdManual, MdRun, MdBurst, MdHalt} mode_e;

  mode_e       m_mode;
  int          m_phase;    // cycles elapsed since the last tick / mode entry
  bit          m_fast;
  int          m_left;
  bit          m_en;
  int unsigned m_count;
  bit          m_pipe1 [3];
  bit          m_pipe2 [3];
  bit          m_level [3];
  bit          m_press [3];
  bit          m_win   [3][$];

  function automatic void model_reset();
    m_mode  = MdManual;
    m_phase = 0;
    m_fast  = 0;
    m_left  = 0;
    m_en    = 0;
    m_count = 0;
    for (int k = 0; k < 3; k++) begin
      m_pipe1[k] = 1;
      m_pipe2[k] = 1;
      m_level[k] = 1;
      m_press[k] = 0;
      m_win[k].delete();
    end
  endfunction

  function automatic void model_step();
    int    div    = (bus.iFDiv == 0) ? 1 : int'(bus.iFDiv);
    int    period = m_fast ? div : (div << SS);
    bit    active = (m_mode == MdRun) || (m_mode == MdBurst);
    bit    tick   = active && (m_phase + 1 >= period);
    mode_e nmode  = m_mode;
    bit    nen    = 0;
    bit    brk    = bus.iBreak;
    case (m_mode)
      MdManual: begin
        nen = m_press[STEP];
        if (bus.iBurstStart && bus.iBurstLen != 0) begin
          nmode  = MdBurst;
          m_left = int'(bus.iBurstLen);
        end else if (m_press[AUTO]) nmode = MdRun;
      end
      MdRun: begin
        if (brk) nmode = MdHalt;
        else if (m_press[AUTO]) nmode = MdManual;
        else nen = tick;
      end
      MdBurst: begin
        if (brk) begin
          nmode  = MdHalt;
          m_left = 0;
        end else if (tick) begin
          nen = 1;
          m_left--;
          if (m_left == 0) nmode = MdManual;
        end
      end
      default: if (m_press[STEP] && !brk) nmode = MdManual;
    endcase
    if (active && (nmode == MdRun || nmode == MdBurst)) m_phase = tick ? 0 : m_phase + 1;
    else m_phase = 0;
    if (m_en) m_count++;
    m_en   = nen;
    m_mode = nmode;
    if (m_press[FAST]) m_fast = !m_fast;
    for (int k = 0; k < 3; k++) begin
      bit all_new = 1;
      m_press[k] = 0;
      m_win[k].push_back(m_pipe2[k]);
      if (m_win[k].size() > DEB) void'(m_win[k].pop_front());
      foreach (m_win[k][i]) if (m_win[k][i] == m_level[k]) all_new = 0;
      if (m_win[k].size() == DEB && all_new) begin
        m_level[k] = !m_level[k];
        m_press[k] = (m_level[k] == 0);
      end
      m_pipe2[k] = m_pipe1[k];
      m_pipe1[k] = bus.iKEY[k];
    end
  endfunction

  task automatic compare_all();
    check_eq("clken", 32'(bus.oCLKEn), 32'(m_en));
    check_eq("auto", 32'(bus.oSelectAuto), 32'(m_mode == MdRun));
    check_eq("fast", 32'(bus.oSelectFast), 32'(m_fast));
    check_eq("running", 32'(bus.oRunning), 32'(m_mode == MdRun || m_mode == MdBurst));
    check_eq("halted", 32'(bus.oHalted), 32'(m_mode == MdHalt));
`ifdef CLOCK_STEP_CYCLE_COUNTER_EN
    check_eq("count", bus.oCycleCount, m_count);
`else
    check_eq("count", bus.oCycleCount, 32'd0);
`endif
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic cyc();
    @(posedge CLK);
    if (Reset) model_reset();
    else model_step();
    @(negedge CLK);
    compare_all();
    if (bus.oCLKEn) en_seen++;
  endtask

  task automatic press(input int k, input int hold);
    bus.iKEY[k] = 1'b0;
    repeat (hold) cyc();
    bus.iKEY[k] = 1'b1;
    repeat (8) cyc();
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    model_reset();
    #1;
    compare_all();
  endtask

  initial begin
    Reset           = 1'b1;
    bus.iKEY        = 3'b111;
    bus.iFDiv       = 8'd1;
    bus.iBreak      = 1'b0;
    bus.iBurstStart = 1'b0;
    bus.iBurstLen   = '0;
    model_reset();
    repeat (3) cyc();
    Reset = 1'b0;
    check_eq("rst_clken", 32'(bus.oCLKEn), 32'd0);
    check_eq("rst_running", 32'(bus.oRunning), 32'd0);
    check_eq("rst_count", bus.oCycleCount, 32'd0);
    repeat (2) cyc();

    // Single step and glitch rejection.
    en_seen = 0;
    press(STEP, 10);
    check_eq("step_one", en_seen, 1);
    en_seen = 0;
    press(STEP, 2);
    check_eq("glitch_none", en_seen, 0);

    // Free run: fast /3, slow /12, slow /4, fast /1.
    press(FAST, 6);
    bus.iFDiv = 8'd3;
    press(AUTO, 6);
    check_eq("run_auto", 32'(bus.oSelectAuto), 32'd1);
    en_seen = 0;
    repeat (30) cyc();
    check_eq("run_fast3", en_seen, 10);
    press(FAST, 6);
    repeat (12) cyc();
    en_seen = 0;
    repeat (48) cyc();
    check_eq("run_slow12", en_seen, 4);
    bus.iFDiv = 8'd0;
    repeat (12) cyc();
    en_seen = 0;
    repeat (40) cyc();
    check_eq("run_slow4", en_seen, 10);
    press(FAST, 6);
    en_seen = 0;
    repeat (20) cyc();
    check_eq("run_fast1", en_seen, 20);
    press(AUTO, 6);
    check_eq("back_manual", 32'(bus.oSelectAuto), 32'd0);

    // Burst of 5 at fast /2.
    bus.iFDiv       = 8'd2;
    bus.iBurstLen   = 16'd5;
    bus.iBurstStart = 1'b1;
    cyc();
    bus.iBurstStart = 1'b0;
    en_seen = 0;
    repeat (20) cyc();
    check_eq("burst_five", en_seen, 5);
    check_eq("burst_done", 32'(bus.oRunning), 32'd0);

    // Breakpoint from RUN at fast /1.
    bus.iFDiv = 8'd1;
    press(AUTO, 6);
    bus.iBreak = 1'b1;
    cyc();
    check_eq("break_halt", 32'(bus.oHalted), 32'd1);
    press(STEP, 6);
    check_eq("halt_hold", 32'(bus.oHalted), 32'd1);
    bus.iBreak = 1'b0;
    cyc();
    en_seen = 0;
    press(STEP, 6);
    check_eq("halt_exit", 32'(bus.oHalted), 32'd0);
    check_eq("halt_exit_noen", en_seen, 0);

    // Reset in the middle of a burst with three enables left.
    bus.iFDiv       = 8'd2;
    bus.iBurstLen   = 16'd5;
    bus.iBurstStart = 1'b1;
    cyc();
    bus.iBurstStart = 1'b0;
    en_seen = 0;
    for (int i = 0; i < 40 && en_seen < 2; i++) cyc();
    check_eq("burst_two", en_seen, 2);
    pulse_reset();
    check_eq("mid_rst_running", 32'(bus.oRunning), 32'd0);
    repeat (2) cyc();
    Reset = 1'b0;
    en_seen = 0;
    repeat (20) cyc();
    check_eq("mid_rst_noen", en_seen, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 3; k++) if ($urandom_range(0, 5) == 0) bus.iKEY[k] = ~bus.iKEY[k];
      if ($urandom_range(0, 19) == 0) bus.iFDiv = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) bus.iBreak = ~bus.iBreak;
      bus.iBurstStart = ($urandom_range(0, 14) == 0);
      bus.iBurstLen   = 16'($urandom_range(0, 4));
      if ($urandom_range(0, 399) == 0) pulse_reset();
      else Reset = 1'b0;
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/clock_step_controller.md
Name: clock_step_controller

Overview:
- Sequences the processor core clock for board bring-up and debug.
- Replaces ripple-clocked key toggles with one synchronous controller. It emits a single-cycle clock-enable (oCLKEn) to the core, which then runs off CLK.
- Modes: manual single-step from push-button, free-run at a divided rate (slow/fast), and fixed-length burst.
- Halts on a breakpoint request from the core.

Parameters:
- DEBOUNCE_CYCLES, 500000, number of stable CLK cycles before a key level is accepted (10 ms at 50 MHz).
- SLOW_SHIFT, 18, left shift applied to the divider in slow mode.
- BURST_W, 16, width of the burst length.

Ports:
- CLK  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset. All state clears immediately on assertion.
- iKEY  in  3  raw push-buttons, active-low: [2] step, [1] auto/manual toggle, [0] slow/fast toggle.
- iFDiv  in  8  rate divider. 0 is treated as 1.
- iBreak  in  1  breakpoint request from the core, level-sensitive.
- iBurstStart  in  1  one-cycle request to start a burst.
- iBurstLen  in  BURST_W  number of enables in a burst.
- oCLKEn  out  1  one-cycle core clock-enable pulse.
- oSelectAuto  out  1  high in RUN.
- oSelectFast  out  1  rate select: 1 = fast, 0 = slow.
- oRunning  out  1  high in RUN or BURST.
- oHalted  out  1  high in HALT.
- oCycleCount  out  32  count of enables issued (see Optional Feature).

Behaviour:
- Reset values: state=MANUAL; all outputs 0; divider counter 0; burst remaining 0.
- Key path, per key:
  - 2-FF synchronizer, then debounce.
  - A new level is accepted after DEBOUNCE_CYCLES consecutive equal samples.
  - Accepted 1→0 transition produces a one-cycle press pulse.
  - Release produces no pulse.
- Rate:
  - Period P = max(iFDiv,1) when fast; P = max(iFDiv,1) << SLOW_SHIFT when slow.
  - Divider counter is 26 bits.
  - When counter >= P-1: emit tick and set counter to 0; otherwise increment.
  - The >= compare means lowering iFDiv mid-count wraps on the next cycle.
  - Counter clears on every entry to RUN or BURST.
- oSelectFast toggles on each fast-key press, in any state. The new rate applies from the next tick decision.
- State machine:
  - MANUAL:
    - Step press → oCLKEn high exactly one cycle, registered, the cycle after the press pulse.
    - Auto press → RUN.
    - iBurstStart with iBurstLen≠0 → BURST, remaining=iBurstLen. iBurstLen=0 is ignored.
    - Auto press and iBurstStart in the same cycle: BURST wins.
  - RUN:
    - oCLKEn = registered tick.
    - Auto press → MANUAL; no further enables.
    - Step presses are ignored.
  - BURST:
    - Each tick issues oCLKEn and decrements remaining.
    - Tick with remaining=1 issues the last enable, then → MANUAL.
    - Auto presses and new iBurstStart are ignored.
  - HALT:
    - No enables.
    - Step press with iBreak low → MANUAL. The release press does not itself issue an enable.
    - Step press while iBreak is still high is ignored.
- iBreak high in RUN or BURST → HALT next cycle. A tick in that same cycle is suppressed: break has priority.
- Reset mid-burst: remaining clears and no further enables are issued.
- oCLKEn is never high for two consecutive cycles except in RUN/BURST with P=1.

Optional Feature:
- Macro CLOCK_STEP_CYCLE_COUNTER_EN.
- Defined:
  - oCycleCount increments by 1 on every oCLKEn cycle and wraps at 2^32.
  - Cleared by Reset only.
- Undefined: oCycleCount is tied to 0 and no counter logic is synthesized. The port is always present.

Decomposition:
- Shared package:
  - state encoding constants ST_MANUAL, ST_RUN, ST_BURST, ST_HALT (2 bits);
  - divider counter width constant (26);
  - key index constants KEY_STEP=2, KEY_AUTO=1, KEY_FAST=0.
- Sub-module key_debounce, instantiated 3×: synchronizer, stability counter, press pulse output.

Test Plan:
- Bench uses DEBOUNCE_CYCLES=4, SLOW_SHIFT=2.
- Reset, then hold iKEY[2] low for 10 cycles and release → exactly one oCLKEn pulse; a 2-cycle glitch on the key → none.
- Auto press, fast, iFDiv=3 → oSelectAuto=1 and oCLKEn every 3rd cycle. Switch to slow → period 12. Set iFDiv=0 → enable every 4 cycles in slow, every cycle in fast.
- MANUAL, iBurstLen=5, iBurstStart pulse, fast, iFDiv=2 → 5 enables 2 cycles apart, oRunning=1 throughout, then MANUAL with oRunning=0.
- RUN, fast, iFDiv=1, raise iBreak → oHalted=1 next cycle, no enable in the break cycle. Step press with iBreak high → stays HALT. Lower iBreak, step press → MANUAL.
- Assert Reset mid-burst (remaining=3) → outputs 0 immediately, no further enables after release. With the macro defined, oCycleCount=0 after reset and equals the enable count otherwise.
